// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and helpers.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   // Encoding is visible on the state port (debug / LED), so values are fixed.
   typedef enum logic [STATE_W-1:0] {
      ST_RST_PLL   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Double-register the asynchronous input to settle metastability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer in the 25 MHz reference domain.
// Pulses PLL RST, waits for lock with timeout and retry limit, qualifies lock
// stability, then releases the system reset; restarts on lock loss.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 25,
   parameter int LOCK_TIMEOUT   = 250000,
   parameter int STABLE_CYCLES  = 2500,
   parameter int MAX_RETRIES    = 4,
   parameter int CNT_W          = 18
) (
   input  logic               clk_25mhz,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               retry,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [STATE_W-1:0] state,
   output logic [7:0]         loss_count,
   output logic [2:0]         retry_count
);

   // Terminal counts: each timed state exits when the timer equals these.
   localparam logic [CNT_W-1:0] L_RST_END = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_STB_END = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [2:0]       L_MAX_TRY = 3'(MAX_RETRIES);

   logic             w_lk_s;
   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_next;
   logic [2:0]       r_retry;
   logic [2:0]       w_retry_next;
   logic [7:0]       r_loss;
   logic [7:0]       w_loss_next;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic             r_fail;

   sync_2ff u_lock_sync (
      .clk (clk_25mhz),
      .rst (rst),
      .i_d (pll_locked),
      .o_q (w_lk_s)
   );

   // Next-state and counter-update decode.
   always_comb begin
      w_next       = r_state;
      w_retry_next = r_retry;
      w_loss_next  = r_loss;
      case (r_state)
         ST_RST_PLL: begin
            if (r_timer == L_RST_END) w_next = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (w_lk_s) begin
               w_next = ST_STABLE;
            end else if (r_timer == L_TO_END) begin
               w_retry_next = r_retry + 3'd1;
               w_next       = (w_retry_next == L_MAX_TRY) ? ST_FAIL : ST_RST_PLL;
            end
         end
         ST_STABLE: begin
            // A lock glitch only restarts the wait; it is not a timeout.
            if (!w_lk_s) begin
               w_next = ST_WAIT_LOCK;
            end else if (r_timer == L_STB_END) begin
               w_next       = ST_RUN;
               w_retry_next = 3'd0;
            end
         end
         ST_RUN: begin
            if (!w_lk_s) begin
               w_next      = ST_RST_PLL;
               w_loss_next = sat_inc8(r_loss);
            end
         end
         ST_FAIL: begin
            if (retry) begin
               w_next       = ST_RST_PLL;
               w_retry_next = 3'd0;
            end
         end
         default: w_next = ST_RST_PLL;
      endcase
   end

   // Shared timer: clears on any state change, counts only in timed states so it never wraps.
   always_comb begin
      w_timer_next = r_timer;
      if (w_next != r_state) begin
         w_timer_next = '0;
      end else if ((r_state == ST_RST_PLL) || (r_state == ST_WAIT_LOCK) ||
                   (r_state == ST_STABLE)) begin
         w_timer_next = r_timer + CNT_W'(1);
      end
   end

   // State, counters and outputs; outputs decode the next state so they move with state.
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RST_PLL;
         r_timer   <= '0;
         r_retry   <= 3'd0;
         r_loss    <= 8'd0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_timer   <= w_timer_next;
         r_retry   <= w_retry_next;
         r_loss    <= w_loss_next;
         r_pll_rst <= (w_next == ST_RST_PLL) || (w_next == ST_FAIL);
         r_sys_rst <= (w_next != ST_RUN);
         r_ready   <= (w_next == ST_RUN);
         r_fail    <= (w_next == ST_FAIL);
      end
   end

   assign pll_rst     = r_pll_rst;
   assign sys_rst     = r_sys_rst;
   assign ready       = r_ready;
   assign fail        = r_fail;
   assign state       = r_state;
   assign loss_count  = r_loss;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   logic       clk_25mhz = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       retry = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [2:0] state;
   logic [7:0] loss_count;
   logic [2:0] retry_count;

   int n_checks = 0;
   int n_errors = 0;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (20),
      .STABLE_CYCLES  (8),
      .MAX_RETRIES    (2),
      .CNT_W          (18)
   ) dut (
      .clk_25mhz   (clk_25mhz),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .retry       (retry),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .fail        (fail),
      .state       (state),
      .loss_count  (loss_count),
      .retry_count (retry_count)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   // Watchdog in case the sequence stalls.
   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk_25mhz);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
      int cyc = 0;
      while (state != target && cyc < budget) begin
         step();
         cyc++;
      end
      chk(tag, 32'(state), 32'(target));
   endtask

   // Length (cycles) of the current WAIT_LOCK window, bounded.
   task automatic wait_window(output int len);
      len = 0;
      while (state == 3'd1 && len < 60) begin
         step();
         len++;
      end
   endtask

   initial begin
      int c_pll_lo;
      int c_stable;
      int c_run;
      int cyc;
      int bad;
      int win;

      // ---- reset state
      rst = 1'b1; pll_locked = 1'b1; retry = 1'b0;
      repeat (3) step();
      chk("rst_state",   32'(state), 0);
      chk("rst_pll_rst", 32'(pll_rst), 1);
      chk("rst_sys_rst", 32'(sys_rst), 1);
      chk("rst_ready",   32'(ready), 0);
      chk("rst_fail",    32'(fail), 0);
      chk("rst_loss",    32'(loss_count), 0);
      chk("rst_retry",   32'(retry_count), 0);

      // ---- 1: lock present from start. Lock is already synchronized during RST_PLL,
      // so: pll_rst low after edge 4, STABLE after edge 5, RUN after edge 5+8=13.
      rst = 1'b0;
      c_pll_lo = -1; c_stable = -1; c_run = -1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (c_pll_lo < 0 && !pll_rst) c_pll_lo = i;
         if (c_stable < 0 && state == 3'd2) c_stable = i;
         if (c_run < 0 && !sys_rst) c_run = i;
      end
      chk("t1_pll_rst_cycles", c_pll_lo, 4);
      chk("t1_stable_entry",   c_stable, 5);
      chk("t1_sys_rst_fall",   c_run, 13);
      chk("t1_stable_len",     c_run - c_stable, 8);
      chk("t1_ready",          32'(ready), 1);
      chk("t1_state_run",      32'(state), 3);
      chk("t1_pll_rst_low",    32'(pll_rst), 0);

      // ---- retry pulse outside FAIL is ignored
      retry = 1'b1; step(); retry = 1'b0; step();
      chk("t6_retry_in_run_state", 32'(state), 3);
      chk("t6_retry_in_run_ready", 32'(ready), 1);

      // ---- 4: lock loss in RUN; two sync edges then the FSM edge
      pll_locked = 1'b0;
      step(); step();
      chk("t4_still_ready", 32'(ready), 1);
      step();
      chk("t4_ready",   32'(ready), 0);
      chk("t4_sys_rst", 32'(sys_rst), 1);
      chk("t4_state",   32'(state), 0);
      chk("t4_loss1",   32'(loss_count), 1);

      // 299 more losses (300 total) -> saturates at 255
      bad = 0;
      for (int k = 0; k < 299; k++) begin
         pll_locked = 1'b1;
         cyc = 0;
         while (state != 3'd3 && cyc < 40) begin step(); cyc++; end
         if (state != 3'd3) bad++;
         pll_locked = 1'b0;
         cyc = 0;
         while (state != 3'd0 && cyc < 10) begin step(); cyc++; end
         if (state != 3'd0) bad++;
      end
      chk("t4_loop_timeouts", bad, 0);
      chk("t4_loss_sat",      32'(loss_count), 255);

      // ---- 5a: asynchronous reset while in STABLE
      pll_locked = 1'b1;
      wait_state(3'd2, 40, "t5_reach_stable");
      rst = 1'b1;
      #1;
      chk("t5s_state",   32'(state), 0);
      chk("t5s_pll_rst", 32'(pll_rst), 1);
      chk("t5s_sys_rst", 32'(sys_rst), 1);
      chk("t5s_ready",   32'(ready), 0);
      chk("t5s_loss",    32'(loss_count), 0);
      step();
      rst = 1'b0;

      // ---- 2: no lock -> two 20-cycle windows -> FAIL
      pll_locked = 1'b0;
      wait_state(3'd1, 20, "t2_enter_wait1");
      wait_window(win);
      chk("t2_window1", win, 20);
      chk("t2_retry1",  32'(retry_count), 1);
      chk("t2_back_rst", 32'(state), 0);
      wait_state(3'd1, 20, "t2_enter_wait2");
      wait_window(win);
      chk("t2_window2",  win, 20);
      chk("t2_state_fail", 32'(state), 4);
      chk("t2_fail",     32'(fail), 1);
      chk("t2_pll_rst",  32'(pll_rst), 1);
      chk("t2_sys_rst",  32'(sys_rst), 1);
      chk("t2_retry2",   32'(retry_count), 2);
      pll_locked = 1'b1;
      repeat (6) step();
      chk("t2_fail_ignores_lock", 32'(state), 4);
      retry = 1'b1; step(); retry = 1'b0;
      chk("t2_retry_state", 32'(state), 0);
      chk("t2_retry_clr",   32'(retry_count), 0);
      chk("t2_retry_fail",  32'(fail), 0);

      // ---- 3: one timeout first so the retry count is nonzero, then glitch in STABLE
      pll_locked = 1'b0;
      wait_state(3'd1, 20, "t3_enter_wait");
      wait_window(win);
      chk("t3_retry1", 32'(retry_count), 1);
      pll_locked = 1'b1;
      wait_state(3'd2, 20, "t3_enter_stable");
      // Input low for one cycle lands at lk_s while the stable timer is 5.
      repeat (3) step();
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      step(); step();
      chk("t3_glitch_wait",  32'(state), 1);
      chk("t3_retry_kept",   32'(retry_count), 1);
      step();
      chk("t3_restable",     32'(state), 2);
      repeat (7) step();
      chk("t3_no_early_run", 32'(state), 2);
      step();
      chk("t3_run",          32'(state), 3);
      chk("t3_retry_clr",    32'(retry_count), 0);

      // ---- 5b: asynchronous reset while in FAIL
      pll_locked = 1'b0;
      wait_state(3'd4, 200, "t5_reach_fail");
      rst = 1'b1;
      #1;
      chk("t5f_state",   32'(state), 0);
      chk("t5f_fail",    32'(fail), 0);
      chk("t5f_pll_rst", 32'(pll_rst), 1);
      chk("t5f_retry",   32'(retry_count), 0);
      step();
      rst = 1'b0;

      // ---- 6: illegal state encoding recovers to RST_PLL
      pll_locked = 1'b1;
      wait_state(3'd3, 40, "t6_reach_run");
      force dut.r_state = state_t'(3'd5);
      #1;
      chk("t6_forced", 32'(state), 5);
      release dut.r_state;
      step();
      chk("t6_state",   32'(state), 0);
      chk("t6_pll_rst", 32'(pll_rst), 1);
      chk("t6_sys_rst", 32'(sys_rst), 1);
      chk("t6_ready",   32'(ready), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
